// File: rtl/dma_fsm_mc.sv
// Multi-channel DMA control FSM: per-channel sequencers sharing one read and one write streamer.
// Build option: define DMA_FSM_MC_STRICT_PRIO_EN for fixed-priority arbitration instead of round-robin.

module dma_fsm_mc_arb #(
   parameter int NUM_CH   = 2,
   parameter int NUM_DESC = 4,
   parameter int CH_W     = 1,
   parameter int IDX_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          pend_i,
   input  logic [NUM_CH*NUM_DESC-1:0] avail_i,
   input  logic                       done_i,
   output logic                       valid_o,
   output logic [CH_W-1:0]            ch_o,
   output logic [IDX_W-1:0]           idx_o,
   output logic                       fire_o
);
   logic                lock_q, lock_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                found;
   logic [CH_W-1:0]     sel_ch;
   logic [IDX_W-1:0]    sel_idx;
   logic [NUM_DESC-1:0] row;
`ifndef DMA_FSM_MC_STRICT_PRIO_EN
   logic [CH_W-1:0]     ptr_q, ptr_d;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      int c;
      found   = 1'b0;
      sel_ch  = '0;
      sel_idx = '0;
      c       = 0;
`ifdef DMA_FSM_MC_STRICT_PRIO_EN
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && pend_i[i]) begin
            found  = 1'b1;
            sel_ch = CH_W'(i);
         end
      end
`else
      // Search starts one past the last served channel, wrapping.
      for (int i = 1; i <= NUM_CH; i++) begin
         c = (int'(ptr_q) + i) % NUM_CH;
         if (!found && pend_i[c]) begin
            found  = 1'b1;
            sel_ch = CH_W'(c);
         end
      end
`endif
      row = avail_i[int'(sel_ch)*NUM_DESC +: NUM_DESC];
      for (int d = NUM_DESC-1; d >= 0; d--) begin
         if (row[d]) sel_idx = IDX_W'(d);
      end

      lock_d = lock_q;
      ch_d   = ch_q;
      idx_d  = idx_q;
`ifndef DMA_FSM_MC_STRICT_PRIO_EN
      ptr_d  = ptr_q;
`endif
      if (lock_q) begin
         if (done_i) begin
            lock_d = 1'b0;
`ifndef DMA_FSM_MC_STRICT_PRIO_EN
            ptr_d  = ch_q;
`endif
         end
      end else if (found) begin
         lock_d = 1'b1;
         ch_d   = sel_ch;
         idx_d  = sel_idx;
      end
   end

   // NOTE: sequential state is only ever written with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
         ch_q   <= '0;
         idx_q  <= '0;
`ifndef DMA_FSM_MC_STRICT_PRIO_EN
         ptr_q  <= '0;
`endif
      end else begin
         lock_q <= lock_d;
         ch_q   <= ch_d;
         idx_q  <= idx_d;
`ifndef DMA_FSM_MC_STRICT_PRIO_EN
         ptr_q  <= ptr_d;
`endif
      end
   end

   assign valid_o = lock_q;
   assign ch_o    = ch_q;
   assign idx_o   = idx_q;
   assign fire_o  = lock_q & done_i;
endmodule

module dma_fsm_mc #(
   parameter  int NUM_CH   = 2,
   parameter  int NUM_DESC = 4,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_go_i,
   input  logic [NUM_CH-1:0]          ch_abort_i,
   input  logic [NUM_CH*NUM_DESC-1:0] desc_en_i,
   input  logic [NUM_CH*NUM_DESC-1:0] desc_nz_i,
   input  logic [NUM_CH-1:0]          axi_pend_i,
   input  logic                       axi_err_valid_i,
   input  logic [CH_W-1:0]            axi_err_ch_i,
   output logic                       rd_valid_o,
   output logic [CH_W-1:0]            rd_ch_o,
   output logic [IDX_W-1:0]           rd_idx_o,
   input  logic                       rd_done_i,
   output logic                       wr_valid_o,
   output logic [CH_W-1:0]            wr_ch_o,
   output logic [IDX_W-1:0]           wr_idx_o,
   input  logic                       wr_done_i,
   output logic [NUM_CH-1:0]          ch_active_o,
   output logic [NUM_CH-1:0]          ch_done_o,
   output logic [NUM_CH-1:0]          ch_error_o,
   output logic [NUM_CH-1:0]          ch_clear_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_RUN, ST_DONE} ch_state_e;

   ch_state_e                       state_q [NUM_CH];
   logic [NUM_CH-1:0][NUM_DESC-1:0] rd_done_q, wr_done_q;
   logic [NUM_CH-1:0][NUM_DESC-1:0] en_nz, rd_avail, wr_avail;
   logic [NUM_CH-1:0]               abort_q, err_q;
   logic [NUM_CH-1:0]               rd_pend, wr_pend, rd_gnt, wr_gnt, clear;
   logic                            rd_fire, wr_fire;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         en_nz[c]    = desc_en_i[c*NUM_DESC +: NUM_DESC] & desc_nz_i[c*NUM_DESC +: NUM_DESC];
         rd_avail[c] = en_nz[c] & ~rd_done_q[c];
         wr_avail[c] = en_nz[c] & ~wr_done_q[c];
         rd_gnt[c]   = rd_valid_o && (rd_ch_o == CH_W'(c));
         wr_gnt[c]   = wr_valid_o && (wr_ch_o == CH_W'(c));
         // An aborted channel keeps its pending status only while its grant drains.
         rd_pend[c]  = (state_q[c] == ST_RUN) && (|rd_avail[c]) && (!abort_q[c] || rd_gnt[c]);
         wr_pend[c]  = (state_q[c] == ST_RUN) && (|wr_avail[c]) && (!abort_q[c] || wr_gnt[c]);
         clear[c]       = (state_q[c] == ST_DONE) && !ch_go_i[c];
         ch_active_o[c] = (state_q[c] == ST_RUN);
         ch_done_o[c]   = (state_q[c] == ST_DONE);
      end
   end

   assign ch_clear_o = clear;
   assign ch_error_o = err_q;

   dma_fsm_mc_arb #(.NUM_CH(NUM_CH), .NUM_DESC(NUM_DESC), .CH_W(CH_W), .IDX_W(IDX_W)) u_rd_arb (
      .clk     (clk),
      .rst     (rst),
      .pend_i  (rd_pend),
      .avail_i (rd_avail),
      .done_i  (rd_done_i),
      .valid_o (rd_valid_o),
      .ch_o    (rd_ch_o),
      .idx_o   (rd_idx_o),
      .fire_o  (rd_fire)
   );

   dma_fsm_mc_arb #(.NUM_CH(NUM_CH), .NUM_DESC(NUM_DESC), .CH_W(CH_W), .IDX_W(IDX_W)) u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .pend_i  (wr_pend),
      .avail_i (wr_avail),
      .done_i  (wr_done_i),
      .valid_o (wr_valid_o),
      .ch_o    (wr_ch_o),
      .idx_o   (wr_idx_o),
      .fire_o  (wr_fire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_IDLE;
         rd_done_q <= '0;
         wr_done_q <= '0;
         abort_q   <= '0;
         err_q     <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            abort_q[c] <= ch_abort_i[c];
            case (state_q[c])
               ST_IDLE: if (ch_go_i[c]) state_q[c] <= ST_CFG;
               ST_CFG:  state_q[c] <= (!abort_q[c] && (|en_nz[c])) ? ST_RUN : ST_DONE;
               ST_RUN:  if (!rd_pend[c] && !wr_pend[c] && !rd_gnt[c] && !wr_gnt[c] && !axi_pend_i[c])
                           state_q[c] <= ST_DONE;
               ST_DONE: if (!ch_go_i[c]) state_q[c] <= ST_IDLE;
               default: state_q[c] <= ST_IDLE;
            endcase

            if (rd_fire && rd_gnt[c]) rd_done_q[c][rd_idx_o] <= 1'b1;
            if (wr_fire && wr_gnt[c]) wr_done_q[c][wr_idx_o] <= 1'b1;
            if (clear[c]) begin
               rd_done_q[c] <= '0;
               wr_done_q[c] <= '0;
            end

            // Clear wins over a coincident error set.
            if (clear[c])
               err_q[c] <= 1'b0;
            else if (axi_err_valid_i && (axi_err_ch_i == CH_W'(c)) && (state_q[c] != ST_IDLE))
               err_q[c] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dma_fsm_mc.sv
// Directed testbench for dma_fsm_mc (NUM_CH=2, NUM_DESC=4) with hand-computed expectations.
// Honours DMA_FSM_MC_STRICT_PRIO_EN for the arbitration-order scenario.

module tb_dma_fsm_mc;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ch_go_i, ch_abort_i, axi_pend_i;
   logic [7:0] desc_en_i, desc_nz_i;
   logic       axi_err_valid_i;
   logic [0:0] axi_err_ch_i;
   logic       rd_valid_o, wr_valid_o, rd_done_i, wr_done_i;
   logic [0:0] rd_ch_o, wr_ch_o;
   logic [1:0] rd_idx_o, wr_idx_o;
   logic [1:0] ch_active_o, ch_done_o, ch_error_o, ch_clear_o;

   int n_vec = 0;
   int n_bad = 0;

   dma_fsm_mc #(.NUM_CH(2), .NUM_DESC(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .ch_go_i         (ch_go_i),
      .ch_abort_i      (ch_abort_i),
      .desc_en_i       (desc_en_i),
      .desc_nz_i       (desc_nz_i),
      .axi_pend_i      (axi_pend_i),
      .axi_err_valid_i (axi_err_valid_i),
      .axi_err_ch_i    (axi_err_ch_i),
      .rd_valid_o      (rd_valid_o),
      .rd_ch_o         (rd_ch_o),
      .rd_idx_o        (rd_idx_o),
      .rd_done_i       (rd_done_i),
      .wr_valid_o      (wr_valid_o),
      .wr_ch_o         (wr_ch_o),
      .wr_idx_o        (wr_idx_o),
      .wr_done_i       (wr_done_i),
      .ch_active_o     (ch_active_o),
      .ch_done_o       (ch_done_o),
      .ch_error_o      (ch_error_o),
      .ch_clear_o      (ch_clear_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      ch_go_i         = '0;
      ch_abort_i      = '0;
      axi_pend_i      = '0;
      desc_en_i       = '0;
      desc_nz_i       = '0;
      axi_err_valid_i = 1'b0;
      axi_err_ch_i    = '0;
      rd_done_i       = 1'b0;
      wr_done_i       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".rd_valid"}, rd_valid_o, 0);
      check({tag, ".wr_valid"}, wr_valid_o, 0);
      check({tag, ".rd_ch_idx"}, {rd_ch_o, rd_idx_o}, 0);
      check({tag, ".wr_ch_idx"}, {wr_ch_o, wr_idx_o}, 0);
      check({tag, ".active"}, ch_active_o, 0);
      check({tag, ".done"}, ch_done_o, 0);
      check({tag, ".error"}, ch_error_o, 0);
      check({tag, ".clear"}, ch_clear_o, 0);
   endtask

   // Wait (bounded) for a grant, check it on both streamers, then complete it on both.
   task automatic serve(input int exp_ch, input int exp_idx);
      int n = 0;
      string t;
      t = $sformatf("grant(%0d,%0d)", exp_ch, exp_idx);
      while (rd_valid_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({t, ".rd_valid"}, rd_valid_o, 1);
      check({t, ".rd_ch"}, rd_ch_o, exp_ch);
      check({t, ".rd_idx"}, rd_idx_o, exp_idx);
      check({t, ".wr_valid"}, wr_valid_o, 1);
      check({t, ".wr_ch"}, wr_ch_o, exp_ch);
      check({t, ".wr_idx"}, wr_idx_o, exp_idx);
      rd_done_i = 1'b1;
      wr_done_i = 1'b1;
      tick();
      rd_done_i = 1'b0;
      wr_done_i = 1'b0;
      check({t, ".bubble"}, rd_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_ch [5];
      int exp_idx [5];
      int n_exp;

      // Reset state
      do_reset();
      check_all_zero("reset");

      // Two channels sharing the streamers; ch1 starts one cycle after ch0
      desc_nz_i = 8'hFF;
      desc_en_i = 8'b0010_0101;
      ch_go_i   = 2'b01;
      tick();
      ch_go_i   = 2'b11;
      serve(0, 0);
      serve(1, 1);
      serve(0, 2);
      check("multi.done_ch1_first", ch_done_o, 2'b10);
      check("multi.active_ch0", ch_active_o, 2'b01);
      tick();
      check("multi.done_both", ch_done_o, 2'b11);
      check("multi.active_none", ch_active_o, 2'b00);
      ch_go_i = 2'b00;
      #1;
      check("multi.clear_pulse", ch_clear_o, 2'b11);
      tick();
      check("multi.clear_gone", ch_clear_o, 2'b00);
      check("multi.idle", ch_done_o, 2'b00);

      // No non-empty descriptors: CFG goes straight to DONE
      do_reset();
      desc_en_i = 8'hFF;
      desc_nz_i = 8'h00;
      ch_go_i   = 2'b01;
      tick();
      check("empty.cfg_not_done", ch_done_o, 2'b00);
      check("empty.cfg_no_rd", rd_valid_o, 0);
      tick();
      check("empty.done", ch_done_o, 2'b01);
      check("empty.no_rd", rd_valid_o, 0);
      check("empty.no_wr", wr_valid_o, 0);
      ch_go_i = 2'b00;
      #1;
      check("empty.clear_pulse", ch_clear_o, 2'b01);
      tick();
      check("empty.clear_gone", ch_clear_o, 2'b00);
      check("empty.idle", ch_done_o, 2'b00);

      // Abort while (0,1) is granted
      do_reset();
      desc_en_i = 8'h0F;
      desc_nz_i = 8'hFF;
      ch_go_i   = 2'b01;
      serve(0, 0);
      tick();
      check("abort.grant_valid", rd_valid_o, 1);
      check("abort.grant_idx", rd_idx_o, 1);
      ch_abort_i = 2'b01;
      axi_pend_i = 2'b01;
      tick();
      tick();
      check("abort.held_valid", rd_valid_o, 1);
      check("abort.held_idx", rd_idx_o, 1);
      check("abort.held_wr_idx", wr_idx_o, 1);
      rd_done_i = 1'b1;
      wr_done_i = 1'b1;
      tick();
      rd_done_i = 1'b0;
      wr_done_i = 1'b0;
      check("abort.unlocked", rd_valid_o, 0);
      tick();
      check("abort.no_next_rd", rd_valid_o, 0);
      check("abort.no_next_wr", wr_valid_o, 0);
      check("abort.still_run", ch_active_o, 2'b01);
      axi_pend_i = 2'b00;
      tick();
      check("abort.done", ch_done_o, 2'b01);
      ch_abort_i = 2'b00;
      ch_go_i    = 2'b00;
      tick();

      // Sticky error on ch1; an error aimed at idle ch0 is ignored
      do_reset();
      desc_en_i = 8'h10;
      desc_nz_i = 8'hFF;
      ch_go_i   = 2'b10;
      serve(1, 0);
      axi_pend_i      = 2'b10;
      axi_err_valid_i = 1'b1;
      axi_err_ch_i    = 1'b1;
      tick();
      check("err.set", ch_error_o, 2'b10);
      check("err.run", ch_active_o, 2'b10);
      axi_err_ch_i = 1'b0;
      axi_pend_i   = 2'b00;
      tick();
      axi_err_valid_i = 1'b0;
      check("err.idle_ignored", ch_error_o, 2'b10);
      check("err.done", ch_done_o, 2'b10);
      ch_go_i = 2'b00;
      #1;
      check("err.clear_pulse", ch_clear_o, 2'b10);
      check("err.held_at_clear", ch_error_o, 2'b10);
      tick();
      check("err.cleared", ch_error_o, 2'b00);

      // Both channels continuously pending
      do_reset();
      desc_en_i = 8'hFF;
      desc_nz_i = 8'hFF;
`ifdef DMA_FSM_MC_STRICT_PRIO_EN
      exp_ch  = '{0, 0, 0, 0, 1};
      exp_idx = '{0, 1, 2, 3, 0};
      n_exp   = 5;
`else
      exp_ch  = '{0, 1, 0, 1, 0};
      exp_idx = '{0, 0, 1, 1, 0};
      n_exp   = 4;
`endif
      ch_go_i = 2'b01;
      tick();
      ch_go_i = 2'b11;
      for (int i = 0; i < n_exp; i++) serve(exp_ch[i], exp_idx[i]);

      // Reset while a grant is live, then restart from desc0
      n = 0;
      while (rd_valid_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("rst.grant_live", rd_valid_o, 1);
      rst     = 1'b1;
      ch_go_i = 2'b00;
      tick();
      check_all_zero("rst.mid");
      rst     = 1'b0;
      ch_go_i = 2'b01;
      serve(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/dma_fsm_mc.md
Name: dma_fsm_mc

Overview:
Multi-channel DMA control FSM. It generalises the single-channel descriptor sequencer to NUM_CH independent channels, each with NUM_DESC descriptors. Channels share one read streamer and one write streamer through a round-robin arbiter. It sits between the CSR bank (per-channel go/abort and descriptor qualifiers) and the AXI read/write streamers. It also adds per-channel abort, sticky per-channel error and a per-channel clear pulse.

Parameters:
NUM_CH, 2, number of DMA channels (1..8)
NUM_DESC, 4, descriptors per channel (1..16)
CH_W, $clog2(NUM_CH) min 1, channel index width (localparam)
IDX_W, $clog2(NUM_DESC) min 1, descriptor index width (localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ch_go_i  in  NUM_CH  per-channel go level from CSR
ch_abort_i  in  NUM_CH  per-channel abort request level
desc_en_i  in  NUM_CH*NUM_DESC  descriptor enable; bit [c*NUM_DESC+d]
desc_nz_i  in  NUM_CH*NUM_DESC  descriptor num_bytes != 0
axi_pend_i  in  NUM_CH  channel has outstanding AXI txns
axi_err_valid_i  in  1  AXI error strobe
axi_err_ch_i  in  CH_W  channel owning the error
rd_valid_o / wr_valid_o  out  1  streamer request valid
rd_ch_o / wr_ch_o  out  CH_W  granted channel
rd_idx_o / wr_idx_o  out  IDX_W  granted descriptor
rd_done_i / wr_done_i  in  1  streamer finished the current descriptor (1-cycle pulse)
ch_active_o  out  NUM_CH  channel in RUN
ch_done_o  out  NUM_CH  channel in DONE
ch_error_o  out  NUM_CH  sticky error
ch_clear_o  out  NUM_CH  1-cycle pulse on DONE->IDLE

Behaviour:
- Reset: all channel FSMs IDLE; done bitmaps, grants, round-robin pointers, error and abort flops all 0; every output 0.
- Per-channel FSM (registered state, 2 bits):
  - IDLE->CFG when ch_go_i[c]=1.
  - CFG->RUN when abort_ff[c]=0 and any desc_en & desc_nz for the channel; otherwise CFG->DONE.
  - RUN->DONE when the channel has no pending rd descriptor, no pending wr descriptor, is not currently granted on either streamer, and axi_pend_i[c]=0.
  - DONE->IDLE when ch_go_i[c]=0; ch_clear_o[c]=1 in that cycle (combinational on the transition); done bitmaps and ch_error_o[c] are cleared on the next edge.
- Pending rd descriptor for c: the channel is in RUN, some d has en&nz&~rd_done[c][d], and abort_ff[c]=0 or c is currently granted. Same rule for wr using wr_done.
- Abort: abort_ff[c] is registered from ch_abort_i[c] (1-cycle latency). A granted descriptor always runs to its done. After that done, no new grant is issued for an aborted channel.
- Arbiter (rd and wr independent, identical logic):
  - Grant state is a registered lock (valid, ch, idx).
  - When unlocked, pick the next channel at or after rr_ptr+1 (wrapping modulo NUM_CH) with a pending descriptor; pick the lowest pending d within that channel.
  - Lock on the next edge; rd_valid_o is asserted from the registered lock. Request latency is 1 cycle from the pending condition.
  - Lock, ch and idx stay stable until rd_done_i. On done: set rd_done[ch][idx], unlock, rr_ptr<=ch. The next grant appears in the following cycle, so there is a minimum 1-cycle bubble.
  - rd_done_i while unlocked is ignored.
- The rd and wr streamers may serve different channels or descriptors concurrently.
- Errors: axi_err_valid_i sets ch_error_o[axi_err_ch_i] on the next edge, if that channel is not IDLE. A simultaneous set and clear resolves to clear. axi_err_ch_i >= NUM_CH is ignored.
- Descriptor bits changing mid-RUN take effect at the next arbitration.
- rst mid-transfer drops all grants immediately.
- Width: CH_W/IDX_W indices are zero-extended. rr_ptr wraps NUM_CH-1 -> 0.

Optional Feature:
DMA_FSM_MC_STRICT_PRIO_EN
- Defined: rr_ptr is unused; the arbiter always picks the lowest-numbered pending channel (fixed priority), which allows starvation.
- Undefined: round-robin as specified above.
- Grant locking, abort and all other behaviour are identical in both modes.

Test Plan:
- NUM_CH=2. Ch0 desc0,2 enabled, ch1 desc1 enabled; both go. Expect rd grants in order (0,0), (1,1), (0,2), with wr grants the same order. Each channel reaches DONE after its last done with axi_pend=0.
- Ch0 go, all desc_nz=0 -> CFG->DONE in 2 cycles, no rd/wr valid. Deassert go -> ch_clear_o[0] pulse of 1 cycle, then IDLE.
- Ch0 desc0..3 enabled; assert abort while (0,1) is granted -> (0,1) completes, no (0,2) grant, ch0 DONE once axi_pend_i[0]=0.
- axi_err_valid_i with axi_err_ch_i=1 during RUN -> ch_error_o=2'b10 held through DONE; cleared the cycle after ch_clear_o[1].
- Both channels continuously pending. Round-robin: grants alternate ch0, ch1, ch0. STRICT_PRIO_EN defined: ch0 only until its descriptors are exhausted.
- rst asserted while rd_valid_o=1 -> next cycle all outputs 0 and FSMs IDLE; a later go restarts from desc0.
